nat_tuple_issuer: RTL and testbench
===================================

NAT_TUPLE_ISSUER -- requirements
Module: nat_tuple_issuer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles to wait for conn_valid before declaring timeout.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  32  packet word, big-endian (first wire byte at [31:24]); stream starts at IPv4 header.
REQ-005 SHALL have ports in_valid  input  1 / in_last  input  1 / in_ready  output  1: word accepted when in_valid && in_ready; in_last marks final word.
REQ-006 SHALL have ports tuple_data  output  128 / tuple_valid  output  1: lookup request to the connection table.
REQ-007 SHALL have ports conn_data  input  16 / conn_valid  input  1: lookup response, one-cycle pulse.
REQ-008 SHALL have ports res_port  output  16 / res_status  output  2 / res_valid  output  1: per-packet result.
REQ-009 SHALL have ports pkt_count  output  16 / drop_count  output  16: packets accepted / packets dropped, both saturating.

Function
REQ-010 SHALL implement states IDLE, HDR, DRAIN, LOOKUP, RESULT; in_ready = 1 only in IDLE, HDR, DRAIN.
REQ-011 SHALL keep 4-bit word index w, 0 at first word of each packet, incrementing per accepted word, saturating at 15.
REQ-012 SHALL capture on w=0: version=[31:28], ihl=[27:24]; w=2: protocol=[23:16]; w=3: src_ip; w=4: dst_ip; w=ihl: src_port=[31:16], dst_port=[15:0].
REQ-013 SHALL leave IDLE for HDR on first accepted word; HDR->DRAIN after the w=ihl word if not last; HDR or DRAIN -> LOOKUP/RESULT when in_last accepted.
REQ-014 SHALL classify packet invalid if version!=4, ihl<5, or in_last accepted at w<ihl; invalid packet -> RESULT with res_status=3, no tuple issued, drop_count+1.
REQ-015 SHALL, for valid packet with protocol not 6 or 17, go to RESULT with res_status=2, res_port=0, no tuple issued.
REQ-016 SHALL, for valid TCP/UDP packet, enter LOOKUP the cycle after in_last accepted.
REQ-017 SHALL form tuple_data: [127:104]=0, [103:72]=src_ip, [71:40]=dst_ip, [39:32]=src_port[7:0], [31:24]=src_port[15:8], [23:16]=dst_port[7:0], [15:8]=dst_port[15:8], [7:0]=protocol.
REQ-018 SHALL hold tuple_valid=1 and tuple_data stable for every cycle in LOOKUP.
REQ-019 SHALL, in LOOKUP, count cycles from 0; conn_valid=1 -> res_port=conn_data, res_status=0, RESULT; count reaching TIMEOUT_CYCLES-1 without conn_valid -> res_port=0, res_status=1, drop_count+1, RESULT.
REQ-020 SHALL give conn_valid priority over timeout when both occur in the same cycle.
REQ-021 SHALL ignore conn_valid in any state other than LOOKUP.
REQ-022 SHALL deassert tuple_valid on the edge leaving LOOKUP (no extra valid cycle after conn_valid seen).
REQ-023 SHALL assert res_valid for exactly one cycle in RESULT, then return to IDLE; res_port/res_status hold until next RESULT.
REQ-024 SHALL increment pkt_count once per packet at in_last acceptance; counters stick at 16'hFFFF.
REQ-025 SHALL accept a 1-word packet (in_last at w=0) as invalid (truncated), res_status=3.
REQ-026 SHALL tolerate in_valid gaps in HDR/DRAIN without changing w or captured fields.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, w=0, in_ready=0, tuple_valid=0, tuple_data=0, res_valid=0, res_port=0, res_status=0, pkt_count=0, drop_count=0.
REQ-028 SHALL discard any in-flight packet and outstanding lookup on reset assertion mid-operation; in_ready=1 first cycle after release.

Verification
REQ-029 SHALL pass: UDP, ihl=5, src 10.0.0.1:1234 -> 8.8.8.8:53, conn_valid with conn_data=16'h0500 after 3 cycles -> tuple_data[103:0]=0A000001_08080808_D204_3500_11, res_port=16'h0500, res_status=0, pkt_count=1.
REQ-030 SHALL pass: TCP ihl=6 (one option word), ports at w=6 -> tuple ports from w=6 word, payload drained, single res_valid pulse.
REQ-031 SHALL pass: valid TCP, no conn_valid -> tuple_valid high exactly 64 cycles, res_status=1, drop_count=1.
REQ-032 SHALL pass: ICMP (protocol 1) -> no tuple_valid, res_status=2; version=6 word 0 -> res_status=3, drop_count+1.
REQ-033 SHALL pass: conn_valid on timeout cycle -> res_status=0; reset pulled low mid-LOOKUP -> tuple_valid=0 immediately, counters 0.

Source files
------------

// File: rtl/nat_tuple_issuer.sv
// nat_tuple_issuer: parses IPv4/L4 headers into a 5-tuple lookup and reports a per-packet result
module nat_tuple_issuer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] tuple_data,
  output logic         tuple_valid,
  input  logic [15:0]  conn_data,
  input  logic         conn_valid,
  output logic [15:0]  res_port,
  output logic [1:0]   res_status,
  output logic         res_valid,
  output logic [15:0]  pkt_count,
  output logic [15:0]  drop_count
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, HDR, DRAIN, LOOKUP, RESULT} state_t;
  state_t state, state_nx;
  logic [3:0] w, version, ihl;
  logic [7:0] protocol;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, port_nx;
  logic [CW-1:0] cnt;
  logic [1:0] status_nx;
  logic acc, hdr_ok, l4, timeout, res_ld, drop_inc;
  assign in_ready = reset && (state == IDLE || state == HDR || state == DRAIN);
  assign acc = in_valid && in_ready;
  assign hdr_ok = state != IDLE && version == 4'd4 && ihl >= 4'd5 && w >= ihl;
  assign l4 = protocol == 8'd6 || protocol == 8'd17;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign tuple_valid = state == LOOKUP;
  assign res_valid = state == RESULT;
  assign tuple_data = {24'h0, src_ip, dst_ip, src_port[7:0], src_port[15:8],
                       dst_port[7:0], dst_port[15:8], protocol};
  // next state plus the result/drop decision taken on the edge that enters RESULT
  always_comb begin
    state_nx = state;
    res_ld = 1'b0;
    port_nx = 16'h0;
    status_nx = 2'd0;
    drop_inc = 1'b0;
    case (state)
      IDLE: if (acc) begin
        state_nx = in_last ? RESULT : HDR;
        res_ld = in_last;
        status_nx = 2'd3;
        drop_inc = in_last;
      end
      HDR, DRAIN: if (acc && in_last) begin
        state_nx = (hdr_ok && l4) ? LOOKUP : RESULT;
        res_ld = !(hdr_ok && l4);
        status_nx = hdr_ok ? 2'd2 : 2'd3;
        drop_inc = !hdr_ok;
      end else if (acc && state == HDR && w == ihl) begin
        state_nx = DRAIN;
      end
      LOOKUP: if (conn_valid || timeout) begin
        state_nx = RESULT;
        res_ld = 1'b1;
        port_nx = conn_valid ? conn_data : 16'h0;
        status_nx = conn_valid ? 2'd0 : 2'd1;
        drop_inc = !conn_valid;
      end
      RESULT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  // word index (restarts after the last word) and lookup cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w <= 4'd0;
      cnt <= '0;
    end else begin
      if (acc) w <= in_last ? 4'd0 : (w == 4'd15 ? w : w + 4'd1);
      cnt <= state == LOOKUP ? cnt + 1'b1 : '0;
    end
  end
  // header field capture; HDR-only so a saturated index cannot recapture payload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {version, ihl, protocol, src_ip, dst_ip, src_port, dst_port} <= '0;
    end else if (acc) begin
      if (state == IDLE) {version, ihl} <= in_data[31:24];
      if (state == HDR && w == 4'd2) protocol <= in_data[23:16];
      if (state == HDR && w == 4'd3) src_ip <= in_data;
      if (state == HDR && w == 4'd4) dst_ip <= in_data;
      if (state == HDR && w == ihl) {src_port, dst_port} <= in_data;
    end
  end
  // result registers and saturating packet/drop counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_port <= 16'h0;
      res_status <= 2'd0;
      pkt_count <= 16'h0;
      drop_count <= 16'h0;
    end else begin
      if (res_ld) {res_port, res_status} <= {port_nx, status_nx};
      if (acc && in_last) pkt_count <= pkt_count + {15'd0, pkt_count != 16'hFFFF};
      if (drop_inc) drop_count <= drop_count + {15'd0, drop_count != 16'hFFFF};
    end
  end
endmodule

// File: tb/tb_nat_tuple_issuer.sv
// tb_nat_tuple_issuer: randomized packet stimulus checked against a packet-level reference model
module tb_nat_tuple_issuer;
  logic clk = 0, reset = 0;
  logic [31:0] in_data = 0;
  logic in_valid = 0, in_last = 0, in_ready;
  logic [127:0] tuple_data;
  logic tuple_valid;
  logic [15:0] conn_data = 0;
  logic conn_valid = 0;
  logic [15:0] res_port;
  logic [1:0] res_status;
  logic res_valid;
  logic [15:0] pkt_count, drop_count;
  int checks = 0, errors = 0;
  int exp_pkt = 0, exp_drop = 0;
  logic [31:0] pkt[$];
  logic [127:0] last_tuple;
  int last_tv;
  bit noise = 0;

  nat_tuple_issuer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tuple_data(tuple_data), .tuple_valid(tuple_valid),
    .conn_data(conn_data), .conn_valid(conn_valid), .res_port(res_port),
    .res_status(res_status), .res_valid(res_valid), .pkt_count(pkt_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                       input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp, input int pay);
    pkt.delete();
    pkt.push_back({ver, ihl, 8'h00, 16'h0054});
    pkt.push_back($urandom);
    pkt.push_back({8'd64, proto, 16'h0});
    pkt.push_back(sip);
    pkt.push_back(dip);
    while (pkt.size() < int'(ihl)) pkt.push_back($urandom);
    pkt.push_back({sp, dp});
    for (int i = 0; i < pay; i++) pkt.push_back($urandom);
  endtask

  task automatic send_pkt(input int maxgap);
    bit rdy_ok = 1;
    for (int i = 0; i < pkt.size(); i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        @(negedge clk);
        in_valid = 0;
        in_data = $urandom;
        in_last = 1'($urandom_range(0, 1));
        conn_valid = noise && ($urandom_range(0, 1) == 1);
        conn_data = 16'($urandom);
      end
      @(negedge clk);
      in_valid = 1;
      in_data = pkt[i];
      in_last = (i == pkt.size() - 1);
      conn_valid = noise && ($urandom_range(0, 1) == 1);
      conn_data = 16'($urandom);
      if (in_ready !== 1'b1) rdy_ok = 0;
    end
    checks++;
    if (!rdy_ok) begin
      errors++;
      $display("FAIL in_ready: got 0 while sending a packet, expected 1");
    end
  endtask

  task automatic respond(input int delay, input logic [15:0] cd);
    logic [31:0] w0 = pkt[0];
    logic [31:0] w2, pw;
    logic [3:0] ihl = w0[27:24];
    int n = pkt.size();
    bit ok, l4, done = 0, tuple_ok = 1;
    int exp_status = 0, exp_tv = 0, tv = 0;
    logic [15:0] exp_port = 0;
    logic [127:0] exp_tuple = 0;
    ok = w0[31:28] == 4 && ihl >= 5 && (n - 1) >= int'(ihl);
    l4 = 0;
    if (ok) begin
      w2 = pkt[2];
      pw = pkt[ihl];
      l4 = w2[23:16] == 6 || w2[23:16] == 17;
      exp_tuple = {24'h0, pkt[3], pkt[4], pw[23:16], pw[31:24], pw[7:0], pw[15:8], w2[23:16]};
    end
    exp_pkt++;
    if (!ok) begin exp_status = 3; exp_drop++; end
    else if (!l4) exp_status = 2;
    else if (delay < 0) begin exp_status = 1; exp_tv = 64; exp_drop++; end
    else begin exp_status = 0; exp_port = cd; exp_tv = delay + 1; end
    for (int c = 0; c < 150 && !done; c++) begin
      @(negedge clk);
      in_valid = 0;
      in_last = 0;
      conn_valid = 0;
      if (tuple_valid) begin
        if (tuple_data !== exp_tuple) tuple_ok = 0;
        last_tuple = tuple_data;
        conn_valid = (tv == delay);
        conn_data = cd;
        tv++;
      end
      if (res_valid) begin
        done = 1;
        checks++;
        if (res_status !== 2'(exp_status)) begin
          errors++;
          $display("FAIL res_status: got %0d expected %0d", res_status, exp_status);
        end
        if (exp_status != 3) begin
          checks++;
          if (res_port !== exp_port) begin
            errors++;
            $display("FAIL res_port: got %h expected %h", res_port, exp_port);
          end
        end
        checks++;
        if (pkt_count !== 16'(exp_pkt) || drop_count !== 16'(exp_drop)) begin
          errors++;
          $display("FAIL counters: got pkt %0d drop %0d expected pkt %0d drop %0d",
                   pkt_count, drop_count, exp_pkt, exp_drop);
        end
      end
    end
    conn_valid = 0;
    last_tv = tv;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL res_valid_timeout: got no res_valid in 150 cycles, expected one");
    end
    checks++;
    if (tv != exp_tv) begin
      errors++;
      $display("FAIL tuple_valid_cycles: got %0d expected %0d", tv, exp_tv);
    end
    if (exp_tv > 0) begin
      checks++;
      if (!tuple_ok) begin
        errors++;
        $display("FAIL tuple_data: got %h expected %h", last_tuple, exp_tuple);
      end
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_result: got res_valid %b in_ready %b expected 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, tuple_valid, res_valid, res_status} !== 5'b0 || tuple_data !== 128'h0 ||
        res_port !== 16'h0 || pkt_count !== 16'h0 || drop_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy %b tv %b rv %b st %0d port %h pkt %0d drop %0d expected all 0",
               in_ready, tuple_valid, res_valid, res_status, res_port, pkt_count, drop_count);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_udp_basic();
    build(4, 5, 17, 32'h0A000001, 32'h08080808, 16'd1234, 16'd53, 0);
    send_pkt(0);
    respond(3, 16'h0500);
    checks++;
    if (last_tuple[103:0] !== 104'h0A000001_08080808_D204_3500_11) begin
      errors++;
      $display("FAIL udp_tuple: got %h expected 0a00000108080808d204350011", last_tuple[103:0]);
    end
    checks++;
    if (res_port !== 16'h0500 || res_status !== 2'd0 || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL udp_result: got port %h st %0d pkt %0d expected 0500 0 1", res_port, res_status, pkt_count);
    end
  endtask

  task automatic test_tcp_options();
    build(4, 6, 6, $urandom, $urandom, 16'($urandom), 16'($urandom), 3);
    send_pkt(2);
    respond(5, 16'($urandom));
  endtask

  task automatic test_timeout();
    build(4, 5, 6, $urandom, $urandom, 16'($urandom), 16'($urandom), 1);
    send_pkt(1);
    respond(-1, 16'h0);
    checks++;
    if (last_tv != 64 || res_status !== 2'd1) begin
      errors++;
      $display("FAIL timeout: got cycles %0d st %0d expected 64 1", last_tv, res_status);
    end
  endtask

  task automatic test_icmp_badver();
    build(4, 5, 1, $urandom, $urandom, 16'($urandom), 16'($urandom), 2);
    send_pkt(1);
    respond(0, 16'h1234);
    build(6, 5, 17, $urandom, $urandom, 16'($urandom), 16'($urandom), 2);
    send_pkt(1);
    respond(0, 16'h1234);
  endtask

  task automatic test_conn_on_timeout();
    build(4, 5, 17, $urandom, $urandom, 16'($urandom), 16'($urandom), 0);
    send_pkt(0);
    respond(63, 16'hBEEF);
  endtask

  task automatic test_short();
    build(4, 5, 17, $urandom, $urandom, 16'($urandom), 16'($urandom), 0);
    while (pkt.size() > 1) void'(pkt.pop_back());
    send_pkt(0);
    respond(0, 16'h1);
    build(4, 7, 6, $urandom, $urandom, 16'($urandom), 16'($urandom), 2);
    while (pkt.size() > 6) void'(pkt.pop_back());
    send_pkt(1);
    respond(0, 16'h1);
  endtask

  task automatic test_random(input int count);
    for (int k = 0; k < count; k++) begin
      logic [3:0] ver = ($urandom_range(0, 9) == 0) ? 4'd6 : 4'd4;
      logic [3:0] ihl = ($urandom_range(0, 9) == 0) ? 4'd3 : 4'($urandom_range(5, 8));
      int r = $urandom_range(0, 5);
      logic [7:0] proto = r < 2 ? 8'd6 : r < 4 ? 8'd17 : r == 4 ? 8'd1 : 8'($urandom);
      int d = $urandom_range(0, 9);
      build(ver, ihl, proto, $urandom, $urandom, 16'($urandom), 16'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, pkt.size() - 1)) void'(pkt.pop_back());
      noise = ($urandom_range(0, 1) == 1);
      send_pkt(3);
      noise = 0;
      respond(d == 0 ? -1 : d == 1 ? 63 : $urandom_range(0, 10), 16'($urandom));
    end
  endtask

  task automatic test_reset_mid_lookup();
    build(4, 5, 17, $urandom, $urandom, 16'($urandom), 16'($urandom), 0);
    send_pkt(0);
    repeat (4) begin
      @(negedge clk);
      in_valid = 0;
      in_last = 0;
    end
    checks++;
    if (tuple_valid !== 1'b1) begin
      errors++;
      $display("FAIL in_lookup: got tuple_valid %b expected 1", tuple_valid);
    end
    reset = 0;
    #1;
    checks++;
    if (tuple_valid !== 1'b0 || in_ready !== 1'b0 || pkt_count !== 16'h0 || drop_count !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: got tv %b rdy %b pkt %0d drop %0d expected 0 0 0 0",
               tuple_valid, in_ready, pkt_count, drop_count);
    end
    exp_pkt = 0;
    exp_drop = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || tuple_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_mid_reset: got rdy %b tv %b expected 1 0", in_ready, tuple_valid);
    end
    build(4, 5, 6, $urandom, $urandom, 16'($urandom), 16'($urandom), 1);
    send_pkt(1);
    respond(2, 16'h4242);
  endtask

  initial begin
    test_reset();
    test_udp_basic();
    test_tcp_options();
    test_timeout();
    test_icmp_badver();
    test_conn_on_timeout();
    test_short();
    test_random(30);
    test_reset_mid_lookup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
